// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: FSM states and default widths shared by the FFT bin scheduler files.
package fft_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, SQ_RE, SQ_IM, WRITE, COMMIT} state_t;
   localparam int WIDTH_DEF       = 12;
   localparam int LEVEL_WIDTH_DEF = 8;
   localparam int SHIFT_DEF       = 6;
   localparam int FFT_LEN_DEF     = 64;
   localparam int IDX_W           = $clog2(FFT_LEN_DEF);
endpackage

// File: rtl/fft_mag_acc.sv
// fft_mag_acc: one shared signed squarer accumulating re^2 + im^2, then shift and saturate to a level.
module fft_mag_acc
   import fft_ctrl_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF,
   parameter int SHIFT       = SHIFT_DEF
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic signed [WIDTH-1:0] re,
   input  logic signed [WIDTH-1:0] im,
   input  logic                    load,
   input  logic                    accum,
   output logic [LEVEL_WIDTH-1:0]  level
);
   logic signed [WIDTH-1:0]   op;
   logic signed [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0]        acc, shifted;
   assign op = accum ? im : re;
   // A square always fits in 2*WIDTH bits, so the truncated signed product is exact.
   assign prod = (2*WIDTH)'(op) * (2*WIDTH)'(op);
   assign shifted = acc >> SHIFT;
   assign level = |(shifted >> LEVEL_WIDTH) ? '1 : shifted[LEVEL_WIDTH-1:0];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) acc <= '0;
      else if (load) acc <= prod;
      else if (accum) acc <= acc + prod;
   end
endmodule

// File: rtl/fft_bin_scheduler.sv
// fft_bin_scheduler: turns the first BINS FFT bins into PWM levels and commits whole frames.
// PEAK_HOLD_EN: commit keeps peaks and decays each level by 1 LSB per frame.
module fft_bin_scheduler
   import fft_ctrl_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int BINS        = 8,
   parameter int FFT_LEN     = FFT_LEN_DEF,
   parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF,
   parameter int SHIFT       = SHIFT_DEF
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        sample_valid,
   input  logic                        fft_sync,
   input  logic signed [WIDTH-1:0]     fft_real,
   input  logic signed [WIDTH-1:0]     fft_imag,
   output logic [BINS*LEVEL_WIDTH-1:0] level_out,
   output logic                        frame_done,
   output logic                        busy,
   output logic                        overrun
);
   localparam int IW = $clog2(FFT_LEN) > IDX_W ? $clog2(FFT_LEN) : IDX_W;
   state_t                  state, state_nx;
   logic [IW-1:0]           nxt_idx, cur_idx, idx;
   logic signed [WIDTH-1:0] re_q, im_q;
   logic [LEVEL_WIDTH-1:0]  level;
   logic [LEVEL_WIDTH-1:0]  work [BINS];
   logic [LEVEL_WIDTH-1:0]  outb [BINS];
   logic                    synced, accept, last, load, accum;
   assign cur_idx = fft_sync ? '0 : nxt_idx;
   assign accept = sample_valid && state == IDLE && (synced || fft_sync) && 32'(cur_idx) < BINS;
   assign last = idx == IW'(BINS - 1);
   assign busy = state != IDLE;
   always_comb begin
      load = state == SQ_RE;
      accum = state == SQ_IM;
      state_nx = state == IDLE  ? (accept ? SQ_RE : IDLE) :
                 state == SQ_RE ? SQ_IM :
                 state == SQ_IM ? WRITE :
                 state == WRITE ? (last ? COMMIT : IDLE) : IDLE;
   end
   fft_mag_acc #(.WIDTH(WIDTH), .LEVEL_WIDTH(LEVEL_WIDTH), .SHIFT(SHIFT)) u_mag (
      .clk(clk), .reset_n(reset_n), .re(re_q), .im(im_q),
      .load(load), .accum(accum), .level(level)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         nxt_idx <= '0;
         idx <= '0;
         synced <= 1'b0;
         overrun <= 1'b0;
         frame_done <= 1'b0;
         re_q <= '0;
         im_q <= '0;
         for (int i = 0; i < BINS; i++) begin
            work[i] <= '0;
            outb[i] <= '0;
         end
      end else begin
         state <= state_nx;
         frame_done <= state == COMMIT;
         // Dropped strobes still move the index so the frame stays aligned.
         if (sample_valid && (synced || fft_sync)) begin
            synced <= 1'b1;
            nxt_idx <= cur_idx == IW'(FFT_LEN - 1) ? '0 : cur_idx + IW'(1);
         end
         if (sample_valid && busy) overrun <= 1'b1;
         if (accept) begin
            re_q <= fft_real;
            im_q <= fft_imag;
            idx <= cur_idx;
         end
         for (int i = 0; i < BINS; i++) begin
            if (state == WRITE && 32'(idx) == i) work[i] <= level;
`ifdef PEAK_HOLD_EN
            if (state == COMMIT) outb[i] <= work[i] >= outb[i] ? work[i] : outb[i] - LEVEL_WIDTH'(outb[i] != '0);
`else
            if (state == COMMIT) outb[i] <= work[i];
`endif
         end
      end
   end
   for (genvar i = 0; i < BINS; i++) begin : g_out
      assign level_out[i*LEVEL_WIDTH +: LEVEL_WIDTH] = outb[i];
   end
endmodule

// File: tb/tb_fft_bin_scheduler.sv
// tb_fft_bin_scheduler: random and directed strobes against a cycle-counting frame model.
module tb_fft_bin_scheduler;
   localparam int W = 12, B = 8, N = 64, LW = 8, SH = 6;
   logic clk = 0, reset_n = 1, sample_valid = 0, fft_sync = 0;
   logic signed [W-1:0] fft_real = '0, fft_imag = '0;
   logic [B*LW-1:0] level_out;
   logic frame_done, busy, overrun;
   int n_cmp = 0, n_bad = 0;
   int edge_n = 0, free_at = 0, commit_at = -1, nidx = 0;
   bit synced = 0, ovr = 0;
   int work[B], mout[B];

   fft_bin_scheduler #(.WIDTH(W), .BINS(B), .FFT_LEN(N), .LEVEL_WIDTH(LW), .SHIFT(SH)) dut (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .fft_sync(fft_sync),
      .fft_real(fft_real), .fft_imag(fft_imag), .level_out(level_out),
      .frame_done(frame_done), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 20) $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_n, got, exp);
      end
   endtask

   function automatic int lvl(int re, int im);
      int a;
      a = (re * re + im * im) >> SH;
      return a > (1 << LW) - 1 ? (1 << LW) - 1 : a;
   endfunction

   function automatic int commit_val(int w, int o);
`ifdef PEAK_HOLD_EN
      return w >= o ? w : (o > 0 ? o - 1 : 0);
`else
      return w;
`endif
   endfunction

   function automatic int rnd();
      return $urandom_range(0, 3) == 0 ? -2048 : int'($urandom_range(0, 4095)) - 2048;
   endfunction

   task automatic check_all(input bit fd);
      logic [63:0] e;
      for (int i = 0; i < B; i++) e[i*LW +: LW] = LW'(mout[i]);
      chk("level_out", level_out, e);
      chk("frame_done", 64'(frame_done), 64'(fd));
      chk("busy", 64'(busy), 64'(edge_n + 1 < free_at));
      chk("overrun", 64'(overrun), 64'(ovr));
   endtask

   task automatic step(input bit v, input bit s, input int re, input int im);
      int cur;
      bit fd;
      sample_valid = v;
      fft_sync = s;
      fft_real = W'(re);
      fft_imag = W'(im);
      @(posedge clk);
      edge_n++;
      if (v && (synced || s)) begin
         cur = s ? 0 : nidx;
         synced = 1;
         nidx = (cur + 1) % N;
         if (edge_n < free_at) ovr = 1;
         else if (cur < B) begin
            work[cur] = lvl(re, im);
            free_at = edge_n + (cur == B - 1 ? 5 : 4);
            if (cur == B - 1) commit_at = edge_n + 4;
         end
      end
      fd = edge_n == commit_at;
      if (fd) for (int i = 0; i < B; i++) mout[i] = commit_val(work[i], mout[i]);
      #1;
      check_all(fd);
      sample_valid = 0;
      fft_sync = 0;
   endtask

   task automatic idle(input int k);
      repeat (k) step(0, 0, 0, 0);
   endtask

   task automatic frame(input int re, input int im, input int gap);
      for (int b = 0; b < B; b++) begin
         step(1, b == 0, re, im);
         idle(gap);
      end
   endtask

   task automatic do_reset();
      reset_n = 0;
      #1;
      synced = 0;
      nidx = 0;
      ovr = 0;
      free_at = 0;
      commit_at = -1;
      for (int i = 0; i < B; i++) begin
         work[i] = 0;
         mout[i] = 0;
      end
      check_all(0);
      #2 reset_n = 1;
   endtask

   initial begin
      #1 do_reset();
      idle(3);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, rnd(), rnd());
         idle(6);
      end
      frame(100, 0, 31);
      chk("all_156", level_out, {B{8'd156}});
      frame(-2048, -2048, 31);
      chk("all_sat", level_out, {B{8'd255}});
      frame(7, 0, 31);
`ifdef PEAK_HOLD_EN
      chk("small", level_out, {B{8'd254}});
`else
      chk("small", level_out, {B{8'd0}});
`endif
      step(1, 1, 300, 0);
      step(0, 0, 0, 0);
      step(1, 0, 400, 0);
      idle(31);
      chk("overrun_set", 64'(overrun), 64'd1);
      for (int b = 2; b < B; b++) begin
         step(1, 0, 40 * b, 0);
         idle(31);
      end
      for (int b = 0; b < 5; b++) begin
         step(1, b == 0, 200, 0);
         idle(31);
      end
      frame(60, 60, 31);
      for (int f = 0; f < 12; f++) begin
         for (int k = 0; k < B + 2; k++) begin
            step(1, k == 0 || $urandom_range(0, 15) == 0, rnd(), rnd());
            idle($urandom_range(1, 8));
         end
         idle(10);
      end
      step(1, 1, 500, 500);
      step(0, 0, 0, 0);
      do_reset();
      chk("rst_level", level_out, 64'd0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, rnd(), rnd());
         idle(10);
      end
      frame(80, 80, 31);
      chk("peak_200", level_out, {B{8'd200}});
      frame(0, 0, 31);
      frame(0, 0, 31);
`ifdef PEAK_HOLD_EN
      chk("decay", level_out, {B{8'd198}});
`else
      chk("decay", level_out, {B{8'd0}});
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
